alu_issue: RTL and testbench
============================

# alu_issue

Decode/issue register stage that feeds the ALU. Each cycle it accepts one MIPS instruction plus its register-file read data, decodes it into a 6-bit ALU function code, a sign flag and the two 32-bit operands, and holds the result in an output register. Upstream and downstream use a valid/ready handshake, and a flush input discards the held entry. It is the producing end of the ALU's `iA/iB/iALUFun/iSign` interface.

## Interface
- No parameters.
- `iClk` in 1: clock; all state updates on the rising edge.
- `iReset` in 1: synchronous, active-high reset.
- `iValid` in 1: the instruction and operand data inputs are valid.
- `oReady` out 1: the stage can accept a new instruction; equals `~oValid | iReady`.
- `iInstr` in 32: MIPS instruction word.
- `iRsData` in 32: register-file value for rs.
- `iRtData` in 32: register-file value for rt.
- `iFlush` in 1: discard the held entry and any entry being accepted this cycle.
- `oValid` out 1: the output register holds an entry.
- `iReady` in 1: the ALU side consumes the entry this cycle.
- `oA` out 32: ALU operand A.
- `oB` out 32: ALU operand B.
- `oALUFun` out 6: ALU function code.
- `oSign` out 1: signed (1) or unsigned (0) arithmetic and compare.
- `oIllegal` out 1: the held entry did not decode.
- `oIssueCnt` out 16: count of entries consumed downstream; wraps at 16 bits.

## Operation
- ALU function codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, STA 011010, LUI 011011, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, GEZ 111001, GTZ 111111.
- Field names: op=[31:26], rt=[20:16], shamt=[10:6], funct=[5:0], imm=[15:0].
- Immediate extension: sext = imm sign-extended to 32 bits; zext = imm zero-extended to 32 bits.
- R-type (op=0), A=rs, B=rt unless noted:
  - add 0x20: ADD, sign 1. addu 0x21: ADD, sign 0.
  - sub 0x22: SUB, sign 1. subu 0x23: SUB, sign 0.
  - and 0x24: AND. or 0x25: OR. xor 0x26: XOR. nor 0x27: NOR.
  - slt 0x2A: LT, sign 1. sltu 0x2B: LT, sign 0.
  - sll 0x00, srl 0x02, sra 0x03: SLL/SRL/SRA with A=zext shamt, B=rt, sign 0.
  - jr 0x08: STA, A=rs, B=0, sign 0.
- I-type, A=rs:
  - addi 0x08: ADD, sext, sign 1. addiu 0x09: ADD, sext, sign 0.
  - slti 0x0A: LT, sext, sign 1. sltiu 0x0B: LT, sext, sign 0.
  - andi 0x0C / ori 0x0D / xori 0x0E: AND/OR/XOR, zext, sign 0.
  - lui 0x0F: LUI, A=0, B=zext, sign 0.
  - lw 0x23, sw 0x2B: ADD, sext, sign 1.
- Branches, sign 1:
  - beq 0x04: EQ, A=rs, B=rt. bne 0x05: NEQ, A=rs, B=rt.
  - blez 0x06: LEZ, A=rs, B=0. bgtz 0x07: GTZ, A=rs, B=0.
  - op 0x01 with rt=0 (bltz): LT, A=rs, B=0. op 0x01 with rt=1 (bgez): GEZ, A=rs, B=0.
- Illegal encoding (any op/funct/rt not listed): ALUFun=ADD, A=0, B=0, sign 0, oIllegal=1. The entry still flows through the handshake normally.
- Accept when `iValid & oReady & ~iFlush`: load the decoded fields and set oValid=1.
- Consume when `oValid & iReady`: increment oIssueCnt. If no new accept occurs in the same cycle, oValid goes to 0.
- Simultaneous consume and accept: load the new entry, oValid stays 1, the counter increments.
- Stall (`oValid & ~iReady`): oReady=0 and all output registers hold their values.
- Flush: next cycle oValid=0. Any accept in the same cycle is dropped. A consume in the same cycle still counts, and the counter does not change otherwise.
- While oValid=0, the data outputs keep their last values; consumers qualify them with oValid.

## Timing
- Latency: one cycle, input accepted at edge N, visible at outputs after edge N.
- Throughput: one instruction per cycle while iReady=1.
- oReady is combinational from oValid and iReady. There is no combinational path from iInstr to any output.
- Reset: oValid=0, oA=0, oB=0, oALUFun=000000, oSign=0, oIllegal=0, oIssueCnt=0. Reset overrides flush and accept.
- Reset mid-stall: the held entry is lost and the counter is cleared.
- oIssueCnt wraps from 0xFFFF to 0x0000 on a consume.

## Test plan
- Reset, then `addi $t,$s,-1` (0x2228FFFF) with iRsData=5 and iReady=1 -> next cycle oValid=1, ALUFun=000000, A=5, B=0xFFFFFFFF, oSign=1, and oIssueCnt=1 one edge later.
- `sra` with shamt=4 and iRtData=0x80000000 -> ALUFun=100011, A=4, B=0x80000000, oSign=0.
- Back-to-back `sltu` then `lui 0x1234` with iReady held at 1 -> consecutive cycles show LT/sign 0, then LUI/B=0x00001234/A=0; no bubble between them.
- Hold iReady=0 for 3 cycles with iValid=1 -> oReady=0 and outputs frozen; release iReady -> the held entry is consumed, the next entry is accepted on the same edge, and the counter increments by 1.
- Assert iFlush together with iValid while an entry is held -> next cycle oValid=0, the new entry is dropped, and oIssueCnt is unchanged when iReady=0.
- op=0x3F -> oIllegal=1, ALUFun=000000, A=B=0. Then preload oIssueCnt to 0xFFFF via 65535 consumes and consume once more -> 0x0000.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: decode/issue register stage in front of the ALU.
// Decodes a MIPS word into ALU function, sign flag and operands.
module alu_issue (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iValid,
  output logic        oReady,
  input  logic [31:0] iInstr,
  input  logic [31:0] iRsData,
  input  logic [31:0] iRtData,
  input  logic        iFlush,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oA,
  output logic [31:0] oB,
  output logic [5:0]  oALUFun,
  output logic        oSign,
  output logic        oIllegal,
  output logic [15:0] oIssueCnt
);

  localparam logic [5:0] FunAdd = 6'b000000;
  localparam logic [5:0] FunSub = 6'b000001;
  localparam logic [5:0] FunAnd = 6'b011000;
  localparam logic [5:0] FunOr  = 6'b011110;
  localparam logic [5:0] FunXor = 6'b010110;
  localparam logic [5:0] FunNor = 6'b010001;
  localparam logic [5:0] FunSta = 6'b011010;
  localparam logic [5:0] FunLui = 6'b011011;
  localparam logic [5:0] FunSll = 6'b100000;
  localparam logic [5:0] FunSrl = 6'b100001;
  localparam logic [5:0] FunSra = 6'b100011;
  localparam logic [5:0] FunEq  = 6'b110011;
  localparam logic [5:0] FunNeq = 6'b110001;
  localparam logic [5:0] FunLt  = 6'b110101;
  localparam logic [5:0] FunLez = 6'b111101;
  localparam logic [5:0] FunGez = 6'b111001;
  localparam logic [5:0] FunGtz = 6'b111111;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rtIdx;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] sext;
  logic [31:0] zext;

  assign op    = iInstr[31:26];
  assign rtIdx = iInstr[20:16];
  assign shamt = iInstr[10:6];
  assign funct = iInstr[5:0];
  assign imm   = iInstr[15:0];
  assign sext  = {{16{imm[15]}}, imm};
  assign zext  = {16'h0000, imm};

  logic [31:0] dA;
  logic [31:0] dB;
  logic [5:0]  dFun;
  logic        dSign;
  logic        dIll;

  always_comb begin
    dA    = iRsData;
    dB    = iRtData;
    dFun  = FunAdd;
    dSign = 1'b0;
    dIll  = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20: begin dFun = FunAdd; dSign = 1'b1; end
          6'h21: dFun = FunAdd;
          6'h22: begin dFun = FunSub; dSign = 1'b1; end
          6'h23: dFun = FunSub;
          6'h24: dFun = FunAnd;
          6'h25: dFun = FunOr;
          6'h26: dFun = FunXor;
          6'h27: dFun = FunNor;
          6'h2A: begin dFun = FunLt; dSign = 1'b1; end
          6'h2B: dFun = FunLt;
          6'h00: begin dFun = FunSll; dA = {27'd0, shamt}; end
          6'h02: begin dFun = FunSrl; dA = {27'd0, shamt}; end
          6'h03: begin dFun = FunSra; dA = {27'd0, shamt}; end
          6'h08: begin dFun = FunSta; dB = '0; end
          default: dIll = 1'b1;
        endcase
      end
      6'h08: begin dFun = FunAdd; dB = sext; dSign = 1'b1; end
      6'h09: begin dFun = FunAdd; dB = sext; end
      6'h0A: begin dFun = FunLt;  dB = sext; dSign = 1'b1; end
      6'h0B: begin dFun = FunLt;  dB = sext; end
      6'h0C: begin dFun = FunAnd; dB = zext; end
      6'h0D: begin dFun = FunOr;  dB = zext; end
      6'h0E: begin dFun = FunXor; dB = zext; end
      6'h0F: begin dFun = FunLui; dA = '0; dB = zext; end
      6'h23, 6'h2B: begin
        dFun = FunAdd; dB = sext; dSign = 1'b1;
      end
      6'h04: begin dFun = FunEq;  dSign = 1'b1; end
      6'h05: begin dFun = FunNeq; dSign = 1'b1; end
      6'h06: begin dFun = FunLez; dB = '0; dSign = 1'b1; end
      6'h07: begin dFun = FunGtz; dB = '0; dSign = 1'b1; end
      6'h01: begin
        dB    = '0;
        dSign = 1'b1;
        case (rtIdx)
          5'd0:    dFun = FunLt;
          5'd1:    dFun = FunGez;
          default: dIll = 1'b1;
        endcase
      end
      default: dIll = 1'b1;
    endcase
    // Illegal words issue as a harmless ADD of zeros.
    if (dIll) begin
      dA    = '0;
      dB    = '0;
      dFun  = FunAdd;
      dSign = 1'b0;
    end
  end

  logic accept;
  logic consume;

  assign oReady  = ~oValid | iReady;
  assign accept  = iValid & oReady & ~iFlush;
  assign consume = oValid & iReady;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      oValid    <= 1'b0;
      oA        <= '0;
      oB        <= '0;
      oALUFun   <= FunAdd;
      oSign     <= 1'b0;
      oIllegal  <= 1'b0;
      oIssueCnt <= '0;
    end else begin
      if (consume) oIssueCnt <= oIssueCnt + 16'd1;
      if (iFlush)       oValid <= 1'b0;
      else if (accept)  oValid <= 1'b1;
      else if (consume) oValid <= 1'b0;
      if (accept) begin
        oA       <= dA;
        oB       <= dB;
        oALUFun  <= dFun;
        oSign    <= dSign;
        oIllegal <= dIll;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized scoreboard bench for alu_issue.
// Driver pushes expected entries; a negedge monitor pops and compares.
module tb_alu_issue;

  logic        iClk = 1'b0;
  logic        iReset, iValid, iFlush, iReady;
  logic [31:0] iInstr, iRsData, iRtData;
  logic        oReady, oValid, oSign, oIllegal;
  logic [31:0] oA, oB;
  logic [5:0]  oALUFun;
  logic [15:0] oIssueCnt;

  always #5 iClk = ~iClk;

  alu_issue dut (
    .iClk(iClk), .iReset(iReset), .iValid(iValid), .oReady(oReady),
    .iInstr(iInstr), .iRsData(iRsData), .iRtData(iRtData),
    .iFlush(iFlush), .oValid(oValid), .iReady(iReady),
    .oA(oA), .oB(oB), .oALUFun(oALUFun), .oSign(oSign),
    .oIllegal(oIllegal), .oIssueCnt(oIssueCnt)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
    logic        ill;
  } ent_t;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  ent_t lastEnt = '0;
  bit   mValid = 1'b0;
  int   nCons = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic ent_t refModel(input logic [31:0] w,
                                    input logic [31:0] rs,
                                    input logic [31:0] rt);
    int op, fn, r;
    logic [31:0] sx, zx, sh;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    r  = int'(w[20:16]);
    sx = 32'($signed(w[15:0]));
    zx = 32'(w[15:0]);
    sh = 32'(w[10:6]);
    if (op == 0) begin
      case (fn)
        'h20: return '{rs, rt, 6'o00, 1'b1, 1'b0};
        'h21: return '{rs, rt, 6'o00, 1'b0, 1'b0};
        'h22: return '{rs, rt, 6'o01, 1'b1, 1'b0};
        'h23: return '{rs, rt, 6'o01, 1'b0, 1'b0};
        'h24: return '{rs, rt, 6'o30, 1'b0, 1'b0};
        'h25: return '{rs, rt, 6'o36, 1'b0, 1'b0};
        'h26: return '{rs, rt, 6'o26, 1'b0, 1'b0};
        'h27: return '{rs, rt, 6'o21, 1'b0, 1'b0};
        'h2A: return '{rs, rt, 6'o65, 1'b1, 1'b0};
        'h2B: return '{rs, rt, 6'o65, 1'b0, 1'b0};
        'h00: return '{sh, rt, 6'o40, 1'b0, 1'b0};
        'h02: return '{sh, rt, 6'o41, 1'b0, 1'b0};
        'h03: return '{sh, rt, 6'o43, 1'b0, 1'b0};
        'h08: return '{rs, 32'd0, 6'o32, 1'b0, 1'b0};
        default: ;
      endcase
    end
    case (op)
      'h08: return '{rs, sx, 6'o00, 1'b1, 1'b0};
      'h09: return '{rs, sx, 6'o00, 1'b0, 1'b0};
      'h0A: return '{rs, sx, 6'o65, 1'b1, 1'b0};
      'h0B: return '{rs, sx, 6'o65, 1'b0, 1'b0};
      'h0C: return '{rs, zx, 6'o30, 1'b0, 1'b0};
      'h0D: return '{rs, zx, 6'o36, 1'b0, 1'b0};
      'h0E: return '{rs, zx, 6'o26, 1'b0, 1'b0};
      'h0F: return '{32'd0, zx, 6'o33, 1'b0, 1'b0};
      'h23, 'h2B: return '{rs, sx, 6'o00, 1'b1, 1'b0};
      'h04: return '{rs, rt, 6'o63, 1'b1, 1'b0};
      'h05: return '{rs, rt, 6'o61, 1'b1, 1'b0};
      'h06: return '{rs, 32'd0, 6'o75, 1'b1, 1'b0};
      'h07: return '{rs, 32'd0, 6'o77, 1'b1, 1'b0};
      'h01: begin
        if (r == 0) return '{rs, 32'd0, 6'o65, 1'b1, 1'b0};
        if (r == 1) return '{rs, 32'd0, 6'o71, 1'b1, 1'b0};
      end
      default: ;
    endcase
    return '{32'd0, 32'd0, 6'o00, 1'b0, 1'b1};
  endfunction

  // Advances the model by one clock edge using the current inputs.
  task automatic cyc(input logic v, input logic [31:0] w,
                     input logic [31:0] rs, input logic [31:0] rt,
                     input logic rdy, input logic fl,
                     input logic rst = 1'b0);
    bit acc, cons;
    iValid = v; iInstr = w; iRsData = rs; iRtData = rt;
    iReady = rdy; iFlush = fl; iReset = rst;
    @(posedge iClk);
    if (rst) begin
      mValid = 0; q.delete(); nCons = 0; lastEnt = '0;
    end else begin
      cons = mValid && rdy;
      acc  = v && (!mValid || rdy) && !fl;
      if (cons) nCons++;
      if (mValid && !rdy && fl && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        lastEnt = refModel(w, rs, rt);
        q.push_back(lastEnt);
      end
      if (fl) mValid = 0;
      else if (acc) mValid = 1;
      else if (cons) mValid = 0;
    end
    #1;
  endtask

  always @(negedge iClk) begin
    ent_t got;
    got = '{oA, oB, oALUFun, oSign, oIllegal};
    chk("valid", 128'(oValid), 128'(mValid));
    chk("ready", 128'(oReady), 128'(!mValid || iReady));
    chk("issueCnt", 128'(oIssueCnt), 128'(nCons % 65536));
    if (oValid) begin
      if (q.size() == 0) chk("qEmpty", 128'(1), 128'(0));
      else chk("entry", 128'(got), 128'(q[0]));
      if (iReady && q.size() > 0) void'(q.pop_front());
    end else begin
      chk("idleHold", 128'(got), 128'(lastEnt));
    end
  end

  logic [5:0] rFun [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
    6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03,
    6'h08, 6'h3F};
  logic [5:0] iOp [17] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
    6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h06,
    6'h07, 6'h01, 6'h01, 6'h3F};

  function automatic logic [31:0] genInstr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: begin
        w[31:26] = 6'h00;
        w[5:0] = rFun[$urandom_range(0, 14)];
      end
      1: w[31:26] = iOp[$urandom_range(0, 16)];
      2: begin
        w[31:26] = 6'h01;
        w[20:16] = 5'($urandom_range(0, 3));
      end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    ent_t got;
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    got = '{oA, oB, oALUFun, oSign, oIllegal};
    chk("resetData", 128'(got), 128'(0));
    chk("resetCnt", 128'(oIssueCnt), 128'(0));

    cyc(1, 32'h2228FFFF, 5, 0, 1, 0);
    chk("addiA", 128'(oA), 128'(5));
    chk("addiB", 128'(oB), 128'(32'hFFFFFFFF));
    chk("addiSign", 128'(oSign), 128'(1));
    w = {6'h00, 5'd0, 5'd9, 5'd8, 5'd4, 6'h03};
    cyc(1, w, 7, 32'h80000000, 1, 0);
    chk("cntAfterAddi", 128'(oIssueCnt), 128'(1));
    chk("sraFun", 128'(oALUFun), 128'(6'b100011));
    chk("sraA", 128'(oA), 128'(4));
    w = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2B};
    cyc(1, w, 1, 2, 1, 0);
    chk("sltuFun", 128'(oALUFun), 128'(6'b110101));
    cyc(1, 32'h3C011234, 9, 9, 1, 0);
    chk("luiB", 128'(oB), 128'(32'h00001234));
    chk("luiValid", 128'(oValid), 128'(1));

    cyc(1, 32'h2108FFF0, 3, 0, 0, 0);
    repeat (3) cyc(1, 32'h3108ABCD, 4, 0, 0, 0);
    chk("stallReady", 128'(oReady), 128'(0));
    cyc(1, 32'h3108ABCD, 4, 0, 1, 0);
    cyc(1, 32'h00430826, 6, 7, 0, 0);
    cyc(1, 32'h2008FFFF, 1, 1, 0, 1);
    chk("flushValid", 128'(oValid), 128'(0));
    cyc(1, 32'hFC000000, 3, 3, 1, 0);
    chk("illFlag", 128'(oIllegal), 128'(1));
    cyc(1, 32'h2108FFF0, 3, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("resetStall", 128'(oIssueCnt), 128'(0));

    repeat (3000) begin
      cyc(($urandom_range(0, 9) < 7), genInstr(), $urandom, $urandom,
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 299) == 0));
    end

    cyc(0, 0, 0, 0, 0, 0, 1);
    while (nCons != 65535) cyc(1, 32'hFC000000, 0, 0, 1, 0);
    chk("cntFFFF", 128'(oIssueCnt), 128'(16'hFFFF));
    cyc(0, 0, 0, 0, 1, 0);
    chk("cntWrap", 128'(oIssueCnt), 128'(0));
    cyc(0, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
